// File: rtl/irq_ctrl.sv
// Six-line (parameterisable) interrupt controller in front of CP0: edge/level capture,
// masking, fixed priority, req/ack handshake to CP0 and nested in-service tracking.
module irq_ctrl #(
   parameter int N_IRQ = 6,
   parameter int VEC_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic             cp0_ie,
   input  logic             cp0_exl,
   input  logic             irq_ack,
   input  logic             eret,
   output logic             irq_req,
   output logic [VEC_W-1:0] irq_vec,
   output logic [N_IRQ-1:0] ip
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [1:0] A_MASK  = 2'd0;
   localparam logic [1:0] A_EDGE  = 2'd1;
   localparam logic [1:0] A_PEND  = 2'd2;
   localparam logic [1:0] A_INSVC = 2'd3;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [VEC_W-1:0] r_vec;
   logic [VEC_W-1:0] w_vec_nxt;

   logic [N_IRQ-1:0] r_mask;
   logic [N_IRQ-1:0] r_edge;
   logic [N_IRQ-1:0] r_pend;
   logic [N_IRQ-1:0] r_insvc;
   logic [N_IRQ-1:0] r_prev;

   logic [N_IRQ-1:0] w_wr_bits;
   logic [N_IRQ-1:0] w_eff;
   logic [VEC_W-1:0] w_top;
   logic [VEC_W-1:0] w_hs;
   logic             w_hs_vld;
   logic             w_above;
   logic             w_elig;
   logic             w_ack;
   logic [N_IRQ-1:0] w_ack_bit;
   logic [N_IRQ-1:0] w_eret_bit;
   logic [N_IRQ-1:0] w_rise;
   logic [N_IRQ-1:0] w_clr;
   logic [N_IRQ-1:0] w_pend_nxt;
   logic [N_IRQ-1:0] w_insvc_nxt;
   logic             w_unused;

   // Index of the highest set bit; zero when nothing is set (callers qualify with |v).
   function automatic logic [VEC_W-1:0] f_hi_idx(input logic [N_IRQ-1:0] v);
      logic [VEC_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         if (v[i]) idx = VEC_W'(i);
      end
      return idx;
   endfunction

   assign w_wr_bits = wdata[N_IRQ-1:0];
   assign w_unused  = ^wdata[31:N_IRQ];

   assign w_eff    = r_pend & r_mask;
   assign w_top    = f_hi_idx(w_eff);
   assign w_hs     = f_hi_idx(r_insvc);
   assign w_hs_vld = |r_insvc;
   assign w_above  = !w_hs_vld || (w_top > w_hs);
   assign w_elig   = (|w_eff) && cp0_ie && !cp0_exl && w_above;

   assign w_ack      = (r_state == S_REQ) && irq_ack;
   assign w_ack_bit  = w_ack ? (N_IRQ'(1) << r_vec) : '0;
   assign w_eret_bit = (eret && w_hs_vld) ? (N_IRQ'(1) << w_hs) : '0;

   // Edge lines: a fresh rise beats both the W1C write and the ack-time clear.
   assign w_rise      = irq_in & ~r_prev;
   assign w_clr       = ((we && (addr == A_PEND)) ? w_wr_bits : '0) | w_ack_bit;
   assign w_pend_nxt  = (~r_edge & irq_in) | (r_edge & (w_rise | (r_pend & ~w_clr)));
   assign w_insvc_nxt = (r_insvc | w_ack_bit) & ~w_eret_bit;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mask  <= '0;
         r_edge  <= '0;
         r_pend  <= '0;
         r_insvc <= '0;
         r_prev  <= '0;
      end else begin
         if (we && (addr == A_MASK)) r_mask <= w_wr_bits;
         if (we && (addr == A_EDGE)) r_edge <= w_wr_bits;
         r_pend  <= w_pend_nxt;
         r_insvc <= w_insvc_nxt;
         r_prev  <= irq_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_vec   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_vec   <= w_vec_nxt;
      end
   end

   // HOLD gives CP0 one cycle to raise EXL before anything new is considered.
   always_comb begin
      w_state_nxt = r_state;
      w_vec_nxt   = r_vec;
      case (r_state)
         S_IDLE: begin
            if (w_elig) begin
               w_state_nxt = S_REQ;
               w_vec_nxt   = w_top;
            end
         end
         S_REQ: begin
            if (irq_ack) begin
               w_state_nxt = S_HOLD;
            end else if (w_elig) begin
               w_vec_nxt = w_top;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_HOLD: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign irq_req = (r_state == S_REQ);
   assign irq_vec = r_vec;
   assign ip      = w_eff;

   always_comb begin
      rdata = '0;
      case (addr)
         A_MASK:  rdata = 32'(r_mask);
         A_EDGE:  rdata = 32'(r_edge);
         A_PEND:  rdata = 32'(r_pend);
         A_INSVC: rdata = 32'(r_insvc);
         default: rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios followed by random traffic, all checked
// every cycle against a behavioural model of the controller's rules.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  irq_in;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        cp0_ie;
   logic        cp0_exl;
   logic        irq_ack;
   logic        eret;
   logic        irq_req;
   logic [2:0]  irq_vec;
   logic [5:0]  ip;

   int n_vec  = 0;
   int n_fail = 0;

   // Model state: register contents plus "request outstanding" and "settling" flags.
   bit [5:0] m_mask, m_edge, m_pend, m_insvc, m_prev;
   bit       m_req, m_hold;
   int       m_vec;

   irq_ctrl #(.N_IRQ(6), .VEC_W(3)) dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .we(we), .addr(addr),
      .wdata(wdata), .rdata(rdata), .cp0_ie(cp0_ie), .cp0_exl(cp0_exl),
      .irq_ack(irq_ack), .eret(eret), .irq_req(irq_req), .irq_vec(irq_vec),
      .ip(ip)
   );

   always #5 clk = ~clk;

   function automatic int highest(bit [5:0] v);
      int r = -1;
      for (int i = 0; i < 6; i++) if (v[i]) r = i;
      return r;
   endfunction

   function automatic bit [31:0] model_rd(logic [1:0] a);
      case (a)
         2'd0:    return {26'd0, m_mask};
         2'd1:    return {26'd0, m_edge};
         2'd2:    return {26'd0, m_pend};
         default: return {26'd0, m_insvc};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      addr = a;
      #1;
      check(tag, rdata, exp);
   endtask

   // Advance one clock: evaluate the rules on the applied inputs, then compare outputs.
   task automatic step();
      bit [5:0] n_mask, n_edge, n_pend, n_insvc;
      bit       n_req, n_hold;
      int       n_vec_m;
      bit [5:0] eff;
      int       top, hs;
      bit       elig, acc;
      eff     = m_pend & m_mask;
      top     = highest(eff);
      hs      = highest(m_insvc);
      elig    = (eff != 0) && cp0_ie && !cp0_exl && (top > hs);
      acc     = m_req && irq_ack;
      n_mask  = m_mask;
      n_edge  = m_edge;
      n_pend  = m_pend;
      n_insvc = m_insvc;
      n_req   = m_req;
      n_hold  = 1'b0;
      n_vec_m = m_vec;
      for (int i = 0; i < 6; i++) begin
         if (!m_edge[i]) n_pend[i] = irq_in[i];
         else if (irq_in[i] && !m_prev[i]) n_pend[i] = 1'b1;
         else if ((we && addr == 2'd2 && wdata[i]) || (acc && m_vec == i)) n_pend[i] = 1'b0;
      end
      if (acc) n_insvc[m_vec] = 1'b1;
      if (eret && hs >= 0) n_insvc[hs] = 1'b0;
      if (we && addr == 2'd0) n_mask = wdata[5:0];
      if (we && addr == 2'd1) n_edge = wdata[5:0];
      if (m_hold) begin
         n_req = 1'b0;
      end else if (m_req) begin
         if (irq_ack) begin
            n_req  = 1'b0;
            n_hold = 1'b1;
         end else if (elig) begin
            n_vec_m = top;
         end else begin
            n_req = 1'b0;
         end
      end else if (elig) begin
         n_req   = 1'b1;
         n_vec_m = top;
      end
      @(posedge clk);
      if (!reset) begin
         m_mask = '0; m_edge = '0; m_pend = '0; m_insvc = '0; m_prev = '0;
         m_req = 1'b0; m_hold = 1'b0; m_vec = 0;
      end else begin
         m_mask = n_mask; m_edge = n_edge; m_pend = n_pend; m_insvc = n_insvc;
         m_prev = irq_in; m_req = n_req; m_hold = n_hold; m_vec = n_vec_m;
      end
      #1;
      check("req", 32'(irq_req), 32'(m_req));
      if (m_req) check("vec", 32'(irq_vec), 32'(m_vec));
      check("ip", 32'(ip), 32'(m_pend & m_mask));
      check("rdata", rdata, model_rd(addr));
      we = 1'b0; irq_ack = 1'b0; eret = 1'b0;
   endtask

   initial begin
      reset = 1'b0; irq_in = '0; we = 1'b0; addr = 2'd0; wdata = '0;
      cp0_ie = 1'b0; cp0_exl = 1'b0; irq_ack = 1'b0; eret = 1'b0;
      m_mask = '0; m_edge = '0; m_pend = '0; m_insvc = '0; m_prev = '0;
      m_req = 1'b0; m_hold = 1'b0; m_vec = 0;

      // 1: reset, level line 2, ack, settle
      step(); step();
      rd(2'd0, 32'h0, "rst_mask"); rd(2'd3, 32'h0, "rst_insvc");
      reset = 1'b1; cp0_ie = 1'b1;
      we = 1'b1; addr = 2'd0; wdata = 32'h3F; step();
      irq_in = 6'h04; step();
      check("t1_nolat", 32'(irq_req), 32'h0);
      step();
      check("t1_req", 32'(irq_req), 32'h1);
      check("t1_vec", 32'(irq_vec), 32'h2);
      irq_ack = 1'b1; step();
      check("t1_req_off", 32'(irq_req), 32'h0);
      rd(2'd3, 32'h04, "t1_insvc");
      step(); step();
      check("t1_noreq", 32'(irq_req), 32'h0);
      irq_in = 6'h00; step();
      eret = 1'b1; step();
      rd(2'd3, 32'h00, "t1_eret");

      // 2: edge capture and W1C
      cp0_ie = 1'b0;
      we = 1'b1; addr = 2'd1; wdata = 32'h3F; step();
      irq_in = 6'h02; step();
      irq_in = 6'h00; step();
      rd(2'd2, 32'h02, "t2_latched");
      irq_in = 6'h02; we = 1'b1; addr = 2'd2; wdata = 32'h02; step();
      rd(2'd2, 32'h02, "t2_set_wins");
      we = 1'b1; addr = 2'd2; wdata = 32'h02; step();
      rd(2'd2, 32'h00, "t2_w1c");
      irq_in = 6'h00; step();

      // 3: priority between lines 1 and 4
      irq_in = 6'h12; step();
      irq_in = 6'h00; step();
      rd(2'd2, 32'h12, "t3_pend");
      cp0_ie = 1'b1; step();
      check("t3_vec4", 32'(irq_vec), 32'h4);
      irq_ack = 1'b1; step();
      rd(2'd3, 32'h10, "t3_insvc");
      step(); step();
      check("t3_blocked", 32'(irq_req), 32'h0);
      eret = 1'b1; step();
      step();
      check("t3_req1", 32'(irq_req), 32'h1);
      check("t3_vec1", 32'(irq_vec), 32'h1);
      irq_ack = 1'b1; step();
      step();
      eret = 1'b1; step();
      rd(2'd3, 32'h00, "t3_insvc0");

      // 4: nesting
      irq_in = 6'h04; step();
      irq_in = 6'h00; step();
      check("t4_vec2", 32'(irq_vec), 32'h2);
      irq_ack = 1'b1; step();
      irq_in = 6'h02; step();
      irq_in = 6'h00; step(); step();
      check("t4_nested_block", 32'(irq_req), 32'h0);
      irq_in = 6'h20; step();
      irq_in = 6'h00; step();
      check("t4_req5", 32'(irq_req), 32'h1);
      check("t4_vec5", 32'(irq_vec), 32'h5);
      irq_ack = 1'b1; step();
      rd(2'd3, 32'h24, "t4_insvc24");
      step();
      eret = 1'b1; step();
      rd(2'd3, 32'h04, "t4_eret1");
      eret = 1'b1; step();
      rd(2'd3, 32'h00, "t4_eret2");
      step();
      check("t4_vec1", 32'(irq_vec), 32'h1);

      // 5: withdrawal by mask, exl and ie
      we = 1'b1; addr = 2'd0; wdata = 32'h0; step();
      step();
      check("t5_mask_drop", 32'(irq_req), 32'h0);
      we = 1'b1; addr = 2'd0; wdata = 32'h3F; step();
      step();
      check("t5_rearm", 32'(irq_req), 32'h1);
      cp0_exl = 1'b1; step();
      check("t5_exl_drop", 32'(irq_req), 32'h0);
      cp0_exl = 1'b0; step();
      cp0_ie = 1'b0; step();
      check("t5_ie_drop", 32'(irq_req), 32'h0);
      cp0_ie = 1'b1; step();
      check("t5_ie_back", 32'(irq_req), 32'h1);

      // 6: reset during REQ
      reset = 1'b0; step();
      check("t6_req", 32'(irq_req), 32'h0);
      check("t6_vec", 32'(irq_vec), 32'h0);
      for (int a = 0; a < 4; a++) rd(2'(a), 32'h0, "t6_rd");
      reset = 1'b1; step();

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         irq_in  = irq_in ^ 6'($urandom_range(0, 63) & $urandom_range(0, 63));
         cp0_ie  = ($urandom_range(0, 7) != 0);
         cp0_exl = ($urandom_range(0, 7) == 0);
         irq_ack = $urandom_range(0, 1) == 1;
         eret    = ($urandom_range(0, 5) == 0);
         we      = ($urandom_range(0, 4) == 0);
         addr    = 2'($urandom_range(0, 3));
         wdata   = $urandom;
         reset   = ($urandom_range(0, 199) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
